// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM states and transaction owner.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   typedef enum logic {
      OWN_IF,
      OWN_DM
   } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side request ports plus the single memory port seen by the arbiter.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  if_req_i;
   logic [ADDR_WIDTH-1:0] if_addr_i;
   logic [DATA_WIDTH-1:0] if_rdata_o;
   logic                  if_ack_o;
   logic                  stall_if_o;
   logic                  dm_req_i;
   logic                  dm_we_i;
   logic [ADDR_WIDTH-1:0] dm_addr_i;
   logic [DATA_WIDTH-1:0] dm_wdata_i;
   logic [DATA_WIDTH-1:0] dm_rdata_o;
   logic                  dm_ack_o;
   logic                  stall_dm_o;
   logic                  mem_en_o;
   logic                  mem_we_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic [DATA_WIDTH-1:0] mem_rdata_i;

   // Arbiter view.
   modport slave (
      input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
      output if_rdata_o, if_ack_o, stall_if_o, dm_rdata_o, dm_ack_o, stall_dm_o,
             mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   // Pipeline plus memory view.
   modport master (
      output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, mem_rdata_i,
      input  if_rdata_o, if_ack_o, stall_if_o, dm_rdata_o, dm_ack_o, stall_dm_o,
             mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data port.
// DM has fixed priority; a streak counter forces an IF grant after STARVE_LIMIT DM wins.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   mem_arbiter_if.slave bus,
   output arb_state_t   dbgState
);

   // Handshake: a requester holds req and its payload until its one-cycle ack; the req
   // level seen in the ack cycle belongs to the finished transaction, not a new one.

   localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(MEM_LATENCY - 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

   arb_state_t            state, nextState;
   owner_t                owner;
   logic [CNT_W-1:0]      cnt;
   logic [STREAK_W-1:0]   streak;
   logic [ADDR_WIDTH-1:0] addrReg;
   logic [DATA_WIDTH-1:0] wdataReg;
   logic [DATA_WIDTH-1:0] ifRdataReg;
   logic [DATA_WIDTH-1:0] dmRdataReg;
   logic                  weReg;
   logic                  anyReq;
   logic                  pickDm;
   logic                  ifAck;
   logic                  dmAck;

   always_comb begin
      anyReq    = bus.if_req_i | bus.dm_req_i;
      pickDm    = bus.dm_req_i & ~(bus.if_req_i & (streak == STREAK_MAX));
      nextState = state;
      case (state)
         IDLE:    if (anyReq) nextState = ISSUE;
         ISSUE:   nextState = WAIT;
         WAIT:    if (cnt == '0) nextState = RESP;
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= nextState;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         owner      <= OWN_IF;
         cnt        <= '0;
         streak     <= '0;
         addrReg    <= '0;
         wdataReg   <= '0;
         weReg      <= 1'b0;
         ifRdataReg <= '0;
         dmRdataReg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (anyReq) begin
                  owner    <= pickDm ? OWN_DM : OWN_IF;
                  addrReg  <= pickDm ? bus.dm_addr_i : bus.if_addr_i;
                  wdataReg <= pickDm ? bus.dm_wdata_i : '0;
                  weReg    <= pickDm & bus.dm_we_i;
                  // Streak only grows while IF is actually being held off.
                  if (pickDm && bus.if_req_i)
                     streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
                  else
                     streak <= '0;
               end
            end
            ISSUE: cnt <= CNT_LOAD;
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (!weReg) begin
                  if (owner == OWN_DM) dmRdataReg <= bus.mem_rdata_i;
                  else                 ifRdataReg <= bus.mem_rdata_i;
               end
            end
            RESP: ;
            default: ;
         endcase
      end
   end

   assign ifAck = (state == RESP) && (owner == OWN_IF);
   assign dmAck = (state == RESP) && (owner == OWN_DM);

   assign bus.if_ack_o    = ifAck;
   assign bus.dm_ack_o    = dmAck;
   assign bus.if_rdata_o  = ifRdataReg;
   assign bus.dm_rdata_o  = dmRdataReg;
   assign bus.stall_if_o  = bus.if_req_i & ~ifAck;
   assign bus.stall_dm_o  = bus.dm_req_i & ~dmAck;
   assign bus.mem_en_o    = (state == ISSUE);
   assign bus.mem_we_o    = (state == ISSUE) & weReg;
   assign bus.mem_addr_o  = addrReg;
   assign bus.mem_wdata_o = wdataReg;
   assign dbgState        = state;

endmodule
